// File: rtl/video_mode_pkg.sv
// Video timing mode descriptors and pixel helpers shared by the display path.
// A mode carries the active size, porches, sync widths and sync polarity per axis.
package video_mode_pkg;

  typedef logic [15:0] cnt_t;

  typedef struct packed {
    cnt_t h_resolution;
    cnt_t h_front_porch;
    cnt_t h_sync;
    cnt_t h_back_porch;
    logic h_sync_pol;     // 1 = active-high sync pulse
    cnt_t v_resolution;
    cnt_t v_front_porch;
    cnt_t v_sync;
    cnt_t v_back_porch;
    logic v_sync_pol;
  } video_mode_t;

  localparam video_mode_t VMODE_640x480p60 = '{
    h_resolution: 16'd640, h_front_porch: 16'd16, h_sync: 16'd96, h_back_porch: 16'd48,
    h_sync_pol: 1'b0,
    v_resolution: 16'd480, v_front_porch: 16'd10, v_sync: 16'd2, v_back_porch: 16'd33,
    v_sync_pol: 1'b0
  };

  // Tiny mode for simulation: 24 x 16 totals.
  localparam video_mode_t VMODE_TEST = '{
    h_resolution: 16'd16, h_front_porch: 16'd2, h_sync: 16'd3, h_back_porch: 16'd3,
    h_sync_pol: 1'b0,
    v_resolution: 16'd12, v_front_porch: 16'd1, v_sync: 16'd2, v_back_porch: 16'd1,
    v_sync_pol: 1'b0
  };

  // Per-pixel control bits carried alongside the RAM read latency.
  typedef struct packed {
    logic de;
    logic in_img;
    logic hsync;
    logic vsync;
  } scan_ctl_t;

  // Extract channel idx (0=red, 1=green, 2=blue) of chan_bits width from a packed pixel.
  function automatic logic [15:0] unpack_chan(input logic [47:0] pix,
                                              input int unsigned chan_bits,
                                              input int unsigned idx);
    logic [47:0] mask;
    mask = (48'd1 << chan_bits) - 48'd1;
    return 16'((pix >> (idx * chan_bits)) & mask);
  endfunction

endpackage

// File: rtl/display_timing.sv
// Free-running x/y raster counters with sync and data-enable decode for any video_mode_t.
// Sync outputs are reported as "active" flags; polarity is applied by the user.
module display_timing
  import video_mode_pkg::*;
#(
  parameter video_mode_t VIDEO_MODE = VMODE_640x480p60
) (
  input  logic clk,
  input  logic rstn,
  output cnt_t x,
  output cnt_t y,
  output logic hsync_act,
  output logic vsync_act,
  output logic de,
  output logic line_last,
  output logic frame_last
);

  localparam cnt_t HA       = VIDEO_MODE.h_resolution;
  localparam cnt_t HS_START = cnt_t'(HA + VIDEO_MODE.h_front_porch);
  localparam cnt_t HS_END   = cnt_t'(HS_START + VIDEO_MODE.h_sync);
  localparam cnt_t HT_LAST  = cnt_t'(HS_END + VIDEO_MODE.h_back_porch - 16'd1);

  localparam cnt_t VA       = VIDEO_MODE.v_resolution;
  localparam cnt_t VS_START = cnt_t'(VA + VIDEO_MODE.v_front_porch);
  localparam cnt_t VS_END   = cnt_t'(VS_START + VIDEO_MODE.v_sync);
  localparam cnt_t VT_LAST  = cnt_t'(VS_END + VIDEO_MODE.v_back_porch - 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x <= '0;
      y <= '0;
    end else if (line_last) begin
      x <= '0;
      y <= frame_last ? '0 : cnt_t'(y + 16'd1);
    end else begin
      x <= cnt_t'(x + 16'd1);
    end
  end

  assign line_last  = (x == HT_LAST);
  assign frame_last = line_last && (y == VT_LAST);
  assign hsync_act  = (x >= HS_START) && (x < HS_END);
  assign vsync_act  = (y >= VS_START) && (y < VS_END);
  assign de         = (x < HA) && (y < VA);

endmodule

// File: rtl/display_scanout.sv
// Scans a centred, integer-upscaled framebuffer out of a synchronous RAM onto VGA pins,
// with border fill, double-buffer swap in vblank and a fixed 2+RD_LATENCY pipeline.
module display_scanout
  import video_mode_pkg::*;
#(
  parameter video_mode_t              VIDEO_MODE = VMODE_640x480p60,
  parameter int                       BUF_W      = 320,
  parameter int                       BUF_H      = 240,
  parameter int                       SCALE      = 2,
  parameter int                       PIX_BITS   = 12,
  parameter int                       CHAN_BITS  = 4,
  parameter int                       RD_LATENCY = 1,
  parameter logic [PIX_BITS-1:0]      BORDER_RGB = '0
) (
  input  logic                               clk,
  input  logic                               rstn,
  output logic [$clog2(BUF_W*BUF_H)-1:0]     fb_addr,
  output logic                               fb_bank,
  output logic                               fb_rd_en,
  input  logic [PIX_BITS-1:0]                fb_data,
  input  logic                               swap_req,
  output logic                               swap_ack,
  output logic                               frame_start,
  output logic                               vga_hsync,
  output logic                               vga_vsync,
  output logic [CHAN_BITS-1:0]               vga_red,
  output logic [CHAN_BITS-1:0]               vga_green,
  output logic [CHAN_BITS-1:0]               vga_blue
);

  localparam int   ADDR_W = $clog2(BUF_W * BUF_H);
  localparam int   SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam cnt_t HA     = VIDEO_MODE.h_resolution;
  localparam cnt_t VA     = VIDEO_MODE.v_resolution;
  localparam cnt_t IMG_W  = cnt_t'(BUF_W * SCALE);
  localparam cnt_t IMG_H  = cnt_t'(BUF_H * SCALE);
  localparam cnt_t XO     = cnt_t'((HA - IMG_W) >> 1);
  localparam cnt_t YO     = cnt_t'((VA - IMG_H) >> 1);
  localparam logic [SW-1:0]     SCALE_LAST = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(BUF_W);

  generate
    if (SCALE < 1 || RD_LATENCY < 1) begin : g_bad_param
      $error("display_scanout: SCALE and RD_LATENCY must be at least 1");
    end
    if (BUF_W * SCALE > int'(HA) || BUF_H * SCALE > int'(VA)) begin : g_bad_geom
      $error("display_scanout: scaled framebuffer does not fit the active area");
    end
    if (PIX_BITS != 3 * CHAN_BITS) begin : g_bad_pix
      $error("display_scanout: PIX_BITS must equal 3*CHAN_BITS");
    end
  endgenerate

  // Stage 0: raster position and decoded window
  cnt_t x, y;
  logic hsync_act, vsync_act, de, line_last, frame_last;

  display_timing #(.VIDEO_MODE(VIDEO_MODE)) u_timing (
    .clk        (clk),
    .rstn       (rstn),
    .x          (x),
    .y          (y),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .de         (de),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  // Unsigned wrap turns the two-sided range test into a single compare.
  logic in_x, in_y, in_img, swap_point, swap_take;
  assign in_x       = cnt_t'(x - XO) < IMG_W;
  assign in_y       = cnt_t'(y - YO) < IMG_H;
  assign in_img     = in_x && in_y;
  assign swap_point = (x == '0) && (y == VA);
  assign swap_take  = swap_point && swap_req;

  // Source column/row trackers always describe the current raster position.
  logic [SW-1:0]     col_sub, row_sub;
  logic [ADDR_W-1:0] src_col, row_base;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_sub  <= '0;
      src_col  <= '0;
      row_sub  <= '0;
      row_base <= '0;
    end else begin
      if (!in_x) begin
        col_sub <= '0;
        src_col <= '0;
      end else if (col_sub == SCALE_LAST) begin
        col_sub <= '0;
        src_col <= src_col + 1'b1;
      end else begin
        col_sub <= col_sub + 1'b1;
      end

      if (frame_last) begin
        row_sub  <= '0;
        row_base <= '0;
      end else if (line_last && in_y) begin
        if (row_sub == SCALE_LAST) begin
          row_sub  <= '0;
          row_base <= row_base + ROW_STEP;
        end else begin
          row_sub <= row_sub + 1'b1;
        end
      end
    end
  end

  // Stage 1 registers plus the control delay line matching the RAM latency.
  scan_ctl_t ctl_pipe [RD_LATENCY+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fb_addr     <= '0;
      fb_rd_en    <= 1'b0;
      fb_bank     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        ctl_pipe[i] <= '0;
      end
    end else begin
      fb_rd_en    <= in_img;
      if (in_img) begin
        fb_addr <= row_base + src_col;
      end
      frame_start <= (x == '0) && (y == '0);
      swap_ack    <= swap_take;
      if (swap_take) begin
        fb_bank <= ~fb_bank;
      end
      ctl_pipe[0] <= '{de: de, in_img: in_img, hsync: hsync_act, vsync: vsync_act};
      for (int i = 1; i <= RD_LATENCY; i++) begin
        ctl_pipe[i] <= ctl_pipe[i-1];
      end
    end
  end

  // Output stage: colour select and channel split.
  scan_ctl_t             ctl_last;
  logic [PIX_BITS-1:0]   pix_next;
  logic [CHAN_BITS-1:0]  chan_next [3];

  assign ctl_last = ctl_pipe[RD_LATENCY];

  always_comb begin
    pix_next = '0;
    if (ctl_last.de) begin
      pix_next = ctl_last.in_img ? fb_data : BORDER_RGB;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_next[gi] = CHAN_BITS'(unpack_chan(48'(pix_next), CHAN_BITS, gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= ~VIDEO_MODE.h_sync_pol;
      vga_vsync <= ~VIDEO_MODE.v_sync_pol;
    end else begin
      vga_red   <= chan_next[0];
      vga_green <= chan_next[1];
      vga_blue  <= chan_next[2];
      vga_hsync <= ctl_last.hsync ? VIDEO_MODE.h_sync_pol : ~VIDEO_MODE.h_sync_pol;
      vga_vsync <= ctl_last.vsync ? VIDEO_MODE.v_sync_pol : ~VIDEO_MODE.v_sync_pol;
    end
  end

endmodule

// File: tb/tb_display_scanout.sv
// Self-checking bench for display_scanout on the small test mode: a position-based
// reference model checked every cycle, plus literal checks of lines, syncs and swaps.
module tb_display_scanout;
  import video_mode_pkg::*;

  localparam int BUF_W = 6;
  localparam int BUF_H = 4;
  localparam int SCALE = 2;
  localparam int L     = 3;
  localparam int HT    = 24;
  localparam int VT    = 16;
  localparam int FT    = HT * VT;
  localparam int SWAP_POS = 12 * HT;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  fb_addr;
  logic        fb_bank, fb_rd_en;
  logic [11:0] fb_data;
  logic        swap_req, swap_ack, frame_start;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_red, vga_green, vga_blue;

  int checks = 0;
  int failures = 0;
  int pcnt;

  display_scanout #(
    .VIDEO_MODE(VMODE_TEST), .BUF_W(BUF_W), .BUF_H(BUF_H), .SCALE(SCALE),
    .PIX_BITS(12), .CHAN_BITS(4), .RD_LATENCY(1), .BORDER_RGB(12'h0F0)
  ) dut (
    .clk(clk), .rstn(rstn), .fb_addr(fb_addr), .fb_bank(fb_bank), .fb_rd_en(fb_rd_en),
    .fb_data(fb_data), .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
  );

  always #5 clk = ~clk;

  // RAM: data = address, with the bank in bit 11 so bank selection is visible.
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= {fb_bank, 6'b0, fb_addr};
  end

  // Cycles since reset release; equals the raster position index.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pcnt <= 0;
    else       pcnt <= pcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t actual=timeout required=event", name, $time);
  endtask

  // Reference model from raster geometry.
  function automatic bit m_in_img(input int q);
    int x = q % HT;
    int y = (q / HT) % VT;
    return x >= 2 && x < 14 && y >= 2 && y < 10;
  endfunction

  function automatic int m_addr(input int q);
    int x = q % HT;
    int y = (q / HT) % VT;
    return ((y - 2) / SCALE) * BUF_W + (x - 2) / SCALE;
  endfunction

  function automatic logic [11:0] m_pix(input int q, input bit bank);
    int x = q % HT;
    int y = (q / HT) % VT;
    logic [11:0] v;
    if (!(x < 16 && y < 12)) return 12'h000;
    if (!m_in_img(q)) return 12'h0F0;
    v = 12'(m_addr(q));
    v[11] = bank;
    return v;
  endfunction

  function automatic logic m_hs(input int q);
    int x = q % HT;
    return (x >= 18 && x < 21) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic m_vs(input int q);
    int y = (q / HT) % VT;
    return (y >= 13 && y < 15) ? 1'b0 : 1'b1;
  endfunction

  // Per-cycle comparison against the model.
  bit mbank, ack_pend;
  bit bank_hist [8];

  always @(negedge clk) begin : cmp
    int p;
    bit exp_rd;
    if (!rstn) begin
      chk("reset_outputs",
          {fb_addr, fb_bank, fb_rd_en, swap_ack, frame_start, vga_hsync, vga_vsync,
           vga_red, vga_green, vga_blue},
          {5'd0, 4'b0000, 2'b11, 12'h000});
      mbank    = 1'b0;
      ack_pend = 1'b0;
    end else begin
      p = pcnt;
      chk("frame_start", frame_start, (p >= 1 && (p - 1) % FT == 0));
      chk("swap_ack", swap_ack, ack_pend);
      chk("fb_bank", fb_bank, mbank);
      exp_rd = (p >= 1) && m_in_img(p - 1);
      chk("fb_rd_en", fb_rd_en, exp_rd);
      if (exp_rd) chk("fb_addr", fb_addr, m_addr(p - 1));
      if (p >= L) begin
        chk("pixel", {vga_blue, vga_green, vga_red}, m_pix(p - L, bank_hist[(p - 2) % 8]));
        chk("hsync", vga_hsync, m_hs(p - L));
        chk("vsync", vga_vsync, m_vs(p - L));
      end else begin
        chk("pipe_fill", {vga_hsync, vga_vsync, vga_blue, vga_green, vga_red}, {2'b11, 12'h000});
      end
      bank_hist[p % 8] = mbank;
      if ((p % FT) == SWAP_POS && swap_req) begin
        ack_pend = 1'b1;
        mbank    = !mbank;
      end else begin
        ack_pend = 1'b0;
      end
    end
  end

  task automatic wait_pos(input int target, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((pcnt % FT) != target && n < budget);
    if ((pcnt % FT) != target) timeout_fail("wait_pos");
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!swap_ack && n < budget);
    if (!swap_ack) timeout_fail(name);
  endtask

  initial begin : stim
    logic [11:0] line2 [24];
    int hs_low, vs_low, fs_cnt, fs_first, fs_second, start, n;
    bit banks [3];
    int rst_at;

    line2 = '{12'h0F0, 12'h0F0, 12'h000, 12'h000, 12'h001, 12'h001, 12'h002, 12'h002,
              12'h003, 12'h003, 12'h004, 12'h004, 12'h005, 12'h005, 12'h0F0, 12'h0F0,
              12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    rstn = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;

    // Line y=2 at the pins, three cycles behind the counter.
    n = 0;
    do begin @(negedge clk); n++; end while (pcnt != L + 2 * HT && n < 200);
    if (pcnt != L + 2 * HT) timeout_fail("line2_align");
    hs_low = 0;
    for (int i = 0; i < HT; i++) begin
      chk($sformatf("line2_x%0d", i), {vga_blue, vga_green, vga_red}, line2[i]);
      if (!vga_hsync) hs_low++;
      @(negedge clk);
    end
    chk("hsync_low_per_line", hs_low, 3);

    // Two full frames of sync and frame_start statistics.
    hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (frame_start) begin
        if (fs_cnt == 0) fs_first = pcnt;
        else             fs_second = pcnt;
        fs_cnt++;
      end
    end
    chk("hsync_low_2frames", hs_low, 2 * VT * 3);
    chk("vsync_low_2frames", vs_low, 2 * 2 * HT);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_period", fs_second - fs_first, FT);

    // Request raised mid-frame: one ack at the first vblank line.
    wait_pos(5 * HT + 7, 2 * FT);
    swap_req = 1'b1;
    wait_ack("s4_ack", 2 * FT);
    chk("s4_ack_pos", pcnt % FT, SWAP_POS + 1);
    chk("s4_bank", fb_bank, 1);
    @(posedge clk); #1 swap_req = 1'b0;

    // Request just after the swap point waits a whole frame.
    wait_pos(SWAP_POS + 1, 2 * FT);
    swap_req = 1'b1;
    start = pcnt;
    wait_ack("s5_ack", 2 * FT);
    chk("s5_ack_delay", pcnt - start, FT);
    chk("s5_bank", fb_bank, 0);
    @(posedge clk); #1 swap_req = 1'b0;

    // Held request: one swap per frame.
    wait_pos(3 * HT, 2 * FT);
    swap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack($sformatf("hold_ack%0d", i), 2 * FT);
      banks[i] = fb_bank;
    end
    @(posedge clk); #1 swap_req = 1'b0;
    chk("hold_bank0", banks[0], 1);
    chk("hold_bank1", banks[1], 0);
    chk("hold_bank2", banks[2], 1);

    // Asynchronous reset mid-line.
    wait_pos(3 * HT + 7, 2 * FT);
    #1 rstn = 1'b0;
    #1 chk("async_reset",
           {fb_addr, fb_bank, fb_rd_en, swap_ack, frame_start, vga_hsync, vga_vsync,
            vga_red, vga_green, vga_blue},
           {5'd0, 4'b0000, 2'b11, 12'h000});
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 50);
    if (!frame_start) timeout_fail("restart_fs");
    chk("restart_fs_cycle", pcnt, 1);
    chk("restart_bank", fb_bank, 0);

    // Randomised swap requests with one random asynchronous reset.
    rst_at = int'($urandom_range(FT, 3 * FT));
    for (int i = 0; i < 4 * FT; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 99) < 3) swap_req = !swap_req;
      if (i == rst_at) begin
        #1 rstn = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        #1 rstn = 1'b1;
      end
    end
    @(posedge clk); #1 swap_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
